video_render_sched: RTL and testbench

VIDEO_RENDER_SCHED -- requirements
Module: video_render_sched

---
 rtl/video_render_sched.sv | 136 +++++++++++++
 tb/tb_video_render_sched.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_render_sched.sv
// Per-scanline render scheduler: sequences layer0, layer1 and sprite jobs
// into the slot opened by each next_line, tracks the line/buffer and overruns.
//   in : clk, rst, next_frame, next_line, en[2:0], done[2:0], overrun_clr
//   out: start[2:0], abort, line_idx, disp_buf, busy, overrun_flag, overrun_cnt
module video_render_sched #(
  parameter int V_ACTIVE = 480,
  parameter int LINE_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              next_frame,
  input  logic              next_line,
  input  logic [2:0]        en,
  input  logic [2:0]        done,
  input  logic              overrun_clr,
  output logic [2:0]        start,
  output logic              abort,
  output logic [LINE_W-1:0] line_idx,
  output logic              disp_buf,
  output logic              busy,
  output logic              overrun_flag,
  output logic [7:0]        overrun_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    L0   = 2'd1,
    L1   = 2'd2,
    SPR  = 2'd3
  } state_t;

  localparam logic [LINE_W:0] VLIM = (LINE_W+1)'(V_ACTIVE);

  state_t            state_q, state_d;
  logic              first_q, first_d;
  logic [2:0]        en_q, en_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              disp_q, disp_d;
  logic              abort_q, abort_d;
  logic              oflag_q, oflag_d;
  logic [7:0]        ocnt_q, ocnt_d;

  logic [2:0] cur_bit;
  logic [2:0] rest;
  logic       fin;
  state_t     adv;
  logic       ovr;
  logic       go;

  function automatic state_t first_of(input logic [2:0] m);
    if (m[0])      return L0;
    else if (m[1]) return L1;
    else if (m[2]) return SPR;
    else           return IDLE;
  endfunction

  always_comb begin
    cur_bit = 3'b000;
    rest    = 3'b000;
    unique case (state_q)
      L0:   begin cur_bit = 3'b001; rest = {en_q[2:1], 1'b0}; end
      L1:   begin cur_bit = 3'b010; rest = {en_q[2], 2'b00}; end
      SPR:  begin cur_bit = 3'b100; rest = 3'b000; end
      default: begin cur_bit = 3'b000; rest = 3'b000; end
    endcase
  end

  assign fin = |(done & cur_bit);
  assign adv = first_of(rest);
  // A slot has completed only if the last enabled job finishes now.
  assign ovr = (state_q != IDLE) && !(fin && adv == IDLE);

  always_comb begin
    state_d = state_q;
    first_d = 1'b0;
    en_d    = en_q;
    line_d  = line_q;
    disp_d  = disp_q;
    abort_d = 1'b0;
    oflag_d = oflag_q;
    ocnt_d  = ocnt_q;
    go      = 1'b0;

    if (fin) begin
      state_d = adv;
      first_d = (adv != IDLE);
    end

    if (overrun_clr) oflag_d = 1'b0;

    if (next_line) begin
      line_d  = next_frame ? '0 : line_q + 1'b1;
      disp_d  = ~disp_q;
      en_d    = en;
      go      = ({1'b0, line_d} < VLIM) && (|en);
      state_d = go ? first_of(en) : IDLE;
      first_d = go;
      abort_d = ovr;
      if (ovr) begin
        oflag_d = 1'b1;
        if (ocnt_q != 8'hFF) ocnt_d = ocnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      first_q <= 1'b0;
      en_q    <= 3'b000;
      line_q  <= '0;
      disp_q  <= 1'b0;
      abort_q <= 1'b0;
      oflag_q <= 1'b0;
      ocnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      en_q    <= en_d;
      line_q  <= line_d;
      disp_q  <= disp_d;
      abort_q <= abort_d;
      oflag_q <= oflag_d;
      ocnt_q  <= ocnt_d;
    end
  end

  assign start        = first_q ? cur_bit : 3'b000;
  assign abort        = abort_q;
  assign line_idx     = line_q;
  assign disp_buf     = disp_q;
  assign busy         = (state_q != IDLE);
  assign overrun_flag = oflag_q;
  assign overrun_cnt  = ocnt_q;

endmodule

// File: tb/tb_video_render_sched.sv
// Bench for video_render_sched: expected start/abort events are queued
// with their cycle and matched by a monitor; status outputs checked inline.
module tb_video_render_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       next_frame = 1'b0;
  logic       next_line = 1'b0;
  logic [2:0] en = 3'b000;
  logic [2:0] done = 3'b000;
  logic       overrun_clr = 1'b0;
  logic [2:0] start;
  logic       abort;
  logic [9:0] line_idx;
  logic       disp_buf;
  logic       busy;
  logic       overrun_flag;
  logic [7:0] overrun_cnt;

  video_render_sched #(.V_ACTIVE(480), .LINE_W(10)) dut (
    .clk(clk), .rst(rst),
    .next_frame(next_frame), .next_line(next_line),
    .en(en), .done(done), .overrun_clr(overrun_clr),
    .start(start), .abort(abort), .line_idx(line_idx),
    .disp_buf(disp_buf), .busy(busy),
    .overrun_flag(overrun_flag), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    bit [2:0] st;
    bit       ab;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [9:0] eline = '0;
  logic       edisp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("start_late", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("start", {29'd0, start}, {29'd0, e.st});
        chk("abort", {31'd0, abort}, {31'd0, e.ab});
      end else if (start != 3'b000 || abort) begin
        chk("unexp_out", {28'd0, start, abort}, 32'd0);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic goto_c(input int t);
    while (cyc < t) tick();
  endtask

  task automatic expect_ev(input int t, input bit [2:0] s, input bit a);
    exp_t e;
    e.cyc = t; e.st = s; e.ab = a;
    exp_q.push_back(e);
  endtask

  task automatic line_at(input int t, input bit nf, input bit [2:0] d,
                         input bit clr);
    goto_c(t);
    next_line = 1'b1;
    next_frame = nf;
    done = d;
    overrun_clr = clr;
    tick();
    next_line = 1'b0;
    next_frame = 1'b0;
    done = 3'b000;
    overrun_clr = 1'b0;
    eline = nf ? 10'd0 : eline + 10'd1;
    edisp = ~edisp;
  endtask

  task automatic done_at(input int t, input bit [2:0] d);
    goto_c(t);
    done = d;
    tick();
    done = 3'b000;
  endtask

  task automatic chk_status(input string tag, input bit b, input bit f,
                            input int n);
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
    chk({tag, "_flag"}, {31'd0, overrun_flag}, {31'd0, f});
    chk({tag, "_cnt"}, {24'd0, overrun_cnt}, n);
    chk({tag, "_line"}, {22'd0, line_idx}, {22'd0, eline});
    chk({tag, "_disp"}, {31'd0, disp_buf}, {31'd0, edisp});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    repeat (3) tick();
    chk("rst_start", {29'd0, start}, 32'd0);
    chk("rst_abort", {31'd0, abort}, 32'd0);
    chk_status("rst", 1'b0, 1'b0, 0);
    rst = 1'b0;
    tick();

    // full three-job slot, done 5 cycles after each start
    en = 3'b111;
    c = cyc;
    expect_ev(c + 1, 3'b001, 1'b0);
    expect_ev(c + 7, 3'b010, 1'b0);
    expect_ev(c + 13, 3'b100, 1'b0);
    line_at(c, 1'b1, 3'b000, 1'b0);
    chk_status("s1", 1'b1, 1'b0, 0);
    done_at(c + 6, 3'b001);
    done_at(c + 12, 3'b010);
    chk("s1_busy_mid", {31'd0, busy}, 32'd1);
    done_at(c + 18, 3'b100);
    chk_status("s1_end", 1'b0, 1'b0, 0);

    // layer1 disabled is skipped
    en = 3'b101;
    c = cyc;
    expect_ev(c + 1, 3'b001, 1'b0);
    expect_ev(c + 4, 3'b100, 1'b0);
    line_at(c, 1'b0, 3'b000, 1'b0);
    done_at(c + 3, 3'b001);
    done_at(c + 5, 3'b100);
    chk_status("s2", 1'b0, 1'b0, 0);

    // stray done ignored, overrun with done[1] withheld
    en = 3'b111;
    c = cyc;
    expect_ev(c + 1, 3'b001, 1'b0);
    line_at(c, 1'b0, 3'b000, 1'b0);
    done_at(c + 2, 3'b001);
    expect_ev(c + 3, 3'b010, 1'b0);
    done_at(c + 4, 3'b101);
    expect_ev(c + 8, 3'b001, 1'b1);
    line_at(c + 7, 1'b0, 3'b000, 1'b0);
    chk_status("s3_ovr", 1'b1, 1'b1, 1);
    en = 3'b000;
    expect_ev(c + 10, 3'b010, 1'b0);
    done_at(c + 9, 3'b001);
    expect_ev(c + 12, 3'b100, 1'b0);
    done_at(c + 11, 3'b010);
    en = 3'b111;
    expect_ev(c + 14, 3'b001, 1'b0);
    line_at(c + 13, 1'b0, 3'b100, 1'b0);
    chk_status("s3_same", 1'b1, 1'b1, 1);
    expect_ev(c + 16, 3'b010, 1'b0);
    done_at(c + 15, 3'b001);
    expect_ev(c + 18, 3'b100, 1'b0);
    done_at(c + 17, 3'b010);
    done_at(c + 19, 3'b100);
    chk_status("s3_end", 1'b0, 1'b1, 1);

    // blanking lines never render
    en = 3'b000;
    while (eline != 10'd479) line_at(cyc, 1'b0, 3'b000, 1'b0);
    chk("s4_479", {22'd0, line_idx}, 32'd479);
    en = 3'b111;
    line_at(cyc, 1'b0, 3'b000, 1'b0);
    chk("s4_480", {22'd0, line_idx}, 32'd480);
    chk("s4_480_busy", {31'd0, busy}, 32'd0);
    while (eline != 10'd524) begin
      line_at(cyc, 1'b0, 3'b000, 1'b0);
      chk("s4_vb_busy", {31'd0, busy}, 32'd0);
    end
    c = cyc;
    expect_ev(c + 1, 3'b001, 1'b0);
    line_at(c, 1'b1, 3'b000, 1'b0);
    chk_status("s4_frame", 1'b1, 1'b1, 1);
    expect_ev(c + 3, 3'b010, 1'b0);
    done_at(c + 2, 3'b001);
    expect_ev(c + 5, 3'b100, 1'b0);
    done_at(c + 4, 3'b010);
    done_at(c + 6, 3'b100);
    chk("s4_idle", {31'd0, busy}, 32'd0);

    // saturate the overrun counter
    en = 3'b001;
    for (int i = 0; i <= 300; i++) begin
      c = cyc;
      expect_ev(c + 1, 3'b001, i > 0);
      line_at(c, 1'b0, 3'b000, 1'b0);
      tick();
    end
    chk_status("s5_sat", 1'b1, 1'b1, 255);
    c = cyc;
    expect_ev(c + 1, 3'b001, 1'b1);
    line_at(c, 1'b0, 3'b000, 1'b1);
    chk_status("s5_setwins", 1'b1, 1'b1, 255);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk_status("s5_clr", 1'b1, 1'b0, 255);

    // reset mid-slot
    rst = 1'b1;
    tick();
    eline = '0;
    edisp = 1'b0;
    chk("s6_rst_abort", {31'd0, abort}, 32'd0);
    tick();
    chk("s6_rst_start", {29'd0, start}, 32'd0);
    chk("s6_rst_abort2", {31'd0, abort}, 32'd0);
    chk_status("s6_rst", 1'b0, 1'b0, 0);
    rst = 1'b0;
    tick();
    c = cyc;
    expect_ev(c + 1, 3'b001, 1'b0);
    line_at(c, 1'b0, 3'b000, 1'b0);
    chk_status("s6_after", 1'b1, 1'b0, 0);
    done_at(c + 2, 3'b001);
    chk("s6_idle", {31'd0, busy}, 32'd0);

    repeat (3) tick();
    chk("q_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
